// File: rtl/bus_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_rr_scheduler
//  Description : Round-robin scheduler for the shared packet bus between the
//                driver FIFOs. Grants one FIFO with a pending head packet,
//                pops it, decodes the 8-bit destination field and pushes the
//                packet into the destination FIFO, or into every FIFO except
//                the source on broadcast. Invalid and self-addressed packets
//                are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_scheduler #(
  parameter int         PCKG_SZ   = 16,
  parameter int         DRVRS     = 8,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DRVRS-1:0]              pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]              pop,
  output logic [DRVRS-1:0]              push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0] D_push,
  output logic [$clog2(DRVRS)-1:0]      grant_id,
  output logic                          busy,
  output logic [15:0]                   pkt_cnt,
  output logic [15:0]                   drop_cnt
);

  localparam int c_gw = $clog2(DRVRS);
  // Pointer starts at the last driver so the first search begins at driver 0.
  localparam logic [c_gw-1:0] c_last_init = c_gw'(DRVRS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_DELIVER = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_gw-1:0]    r_last;
  logic [c_gw-1:0]    r_grant;
  logic [c_gw-1:0]    w_pick;
  logic [c_gw-1:0]    w_scan;
  logic               w_pick_vld;

  logic [PCKG_SZ-1:0] r_bus;
  logic [PCKG_SZ-1:0] r_dpush;
  logic [DRVRS-1:0]   r_pop;
  logic [DRVRS-1:0]   r_push;
  logic [DRVRS-1:0]   w_pop_nxt;
  logic [DRVRS-1:0]   w_push_nxt;
  logic [DRVRS-1:0]   w_gsel;
  logic [15:0]        r_pkt_cnt;
  logic [15:0]        r_drop_cnt;
  logic [7:0]         w_dest;

  logic               w_grant_ld;
  logic               w_bus_ld;
  logic               w_dpush_ld;
  logic               w_pkt_inc;
  logic               w_drop_inc;

  // One-hot select of the currently granted source.
  assign w_gsel = DRVRS'(1) << r_grant;

  // Destination field lives in the top byte of the latched packet.
  assign w_dest = r_bus[PCKG_SZ-1 -: 8];

  // Round-robin search: first pending driver after the last grant, wrapping.
  always_comb begin
    w_pick     = r_last;
    w_pick_vld = 1'b0;
    w_scan     = '0;
    for (int k = 1; k <= DRVRS; k++) begin
      w_scan = c_gw'((int'(r_last) + k) % DRVRS);
      if (!w_pick_vld && pndng[w_scan]) begin
        w_pick     = w_scan;
        w_pick_vld = 1'b1;
      end
    end
  end

  // Next-state and next-output decode for the arbitration FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_nxt   = '0;
    w_push_nxt  = '0;
    w_grant_ld  = 1'b0;
    w_bus_ld    = 1'b0;
    w_dpush_ld  = 1'b0;
    w_pkt_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_grant_ld  = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The source may have withdrawn its request; abandon quietly if so.
        if (pndng[r_grant]) begin
          w_pop_nxt   = w_gsel;
          w_bus_ld    = 1'b1;
          w_state_nxt = ST_DELIVER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        w_dpush_ld = 1'b1;
        if (w_dest == BROADCAST) begin
          w_push_nxt = ~w_gsel;
          w_pkt_inc  = 1'b1;
        end else if ((int'(w_dest) < DRVRS) && (int'(w_dest) != int'(r_grant))) begin
          w_push_nxt = DRVRS'(1) << w_dest;
          w_pkt_inc  = 1'b1;
        end else begin
          // Out-of-range or self-addressed: never loop a packet back to its source.
          w_drop_inc = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant index and round-robin pointer, both updated at arbitration time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant <= '0;
      r_last  <= c_last_init;
    end else if (w_grant_ld) begin
      r_grant <= w_pick;
      r_last  <= w_pick;
    end
  end

  // Registered pop/push strobes; they default low so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pop  <= '0;
      r_push <= '0;
    end else begin
      r_pop  <= w_pop_nxt;
      r_push <= w_push_nxt;
    end
  end

  // Packet capture at pop time and bus data presented at delivery time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus   <= '0;
      r_dpush <= '0;
    end else begin
      if (w_bus_ld) begin
        r_bus <= D_pop[r_grant];
      end
      if (w_dpush_ld) begin
        r_dpush <= r_bus;
      end
    end
  end

  // Delivered/dropped packet counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pkt_inc) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_drop_inc) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Every bus lane carries the same latched packet.
  generate
    for (genvar i = 0; i < DRVRS; i++) begin : g_lane
      assign D_push[i] = r_dpush;
    end
  endgenerate

  assign pop      = r_pop;
  assign push     = r_push;
  assign grant_id = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

`ifndef SYNTHESIS
  // Structural invariants of the bus protocol.
  a_pop_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(r_pop));
  a_no_self_push : assert property (@(posedge clk) disable iff (!reset)
    !(r_push[r_grant]));
  a_one_in_flight : assert property (@(posedge clk) disable iff (!reset)
    !((|r_pop) && (|r_push)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bus_rr_scheduler
//  Description : Self-checking bench for bus_rr_scheduler. Driver FIFOs are
//                modelled as small arrays; expected grants, strobes, bus data
//                and counters come from a packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rr_scheduler;

  localparam int PCKG_SZ = 16;
  localparam int DRVRS   = 8;
  localparam int DEPTH   = 4;

  logic                          clk;
  logic                          reset;
  logic [DRVRS-1:0]              pndng;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]              pop;
  logic [DRVRS-1:0]              push;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_push;
  logic [2:0]                    grant_id;
  logic                          busy;
  logic [15:0]                   pkt_cnt;
  logic [15:0]                   drop_cnt;

  bus_rr_scheduler #(
    .PCKG_SZ  (PCKG_SZ),
    .DRVRS    (DRVRS),
    .BROADCAST(8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .push    (push),
    .D_push  (D_push),
    .grant_id(grant_id),
    .busy    (busy),
    .pkt_cnt (pkt_cnt),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: FIFO contents, RR pointer and counters.
  logic [15:0] fifo_mem [DRVRS][DEPTH];
  int          fifo_cnt [DRVRS];
  int          last_m;
  logic [15:0] pkt_m;
  logic [15:0] drop_m;
  int          n_checks;
  int          n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fifo_push(input int f, input logic [15:0] data);
    if (fifo_cnt[f] < DEPTH) begin
      fifo_mem[f][fifo_cnt[f]] = data;
      fifo_cnt[f]++;
    end
  endtask

  task automatic fifo_pop(input int f);
    for (int i = 0; i < DEPTH - 1; i++) fifo_mem[f][i] = fifo_mem[f][i+1];
    if (fifo_cnt[f] > 0) fifo_cnt[f]--;
  endtask

  // Present FIFO heads; empty FIFOs show garbage data.
  task automatic drive_fifos();
    for (int i = 0; i < DRVRS; i++) begin
      pndng[i] = (fifo_cnt[i] > 0);
      D_pop[i] = (fifo_cnt[i] > 0) ? fifo_mem[i][0] : 16'($urandom);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= DRVRS; k++) begin
      if (fifo_cnt[(last_m + k) % DRVRS] > 0) return (last_m + k) % DRVRS;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < DRVRS; i++) if (fifo_cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_push_mask(input int src, input logic [7:0] d);
    if (d == 8'hFF) return 8'hFF & ~(8'(1) << src);
    if (int'(d) < DRVRS && int'(d) != src) return 8'(1) << d;
    return 8'h00;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_pop"},  32'(pop),      32'h0);
    check_val({tag, "_push"}, 32'(push),     32'h0);
    check_val({tag, "_busy"}, 32'(busy),     32'h0);
    check_val({tag, "_gnt"},  32'(grant_id), 32'h0);
    check_val({tag, "_pkt"},  32'(pkt_cnt),  32'h0);
    check_val({tag, "_drop"}, 32'(drop_cnt), 32'h0);
    for (int j = 0; j < DRVRS; j++) check_val({tag, "_dpush"}, 32'(D_push[j]), 32'h0);
  endtask

  // One arbitration from an idle DUT: sample, pop, deliver.
  task automatic serve_one(output int gobs);
    int          g;
    logic [15:0] pk;
    logic [7:0]  mask;
    g = rr_pick();
    if (g < 0) begin
      gobs = -1;
      @(posedge clk); #1;
      check_val("idle_busy", 32'(busy), 32'h0);
      check_val("idle_pop",  32'(pop),  32'h0);
      return;
    end
    pk = fifo_mem[g][0];
    @(posedge clk); #1;
    last_m = g;
    gobs   = int'(grant_id);
    check_val("grant",      32'(grant_id), 32'(g));
    check_val("busy_issue", 32'(busy),     32'h1);
    check_val("pop_early",  32'(pop),      32'h0);
    @(posedge clk); #1;
    check_val("pop",        32'(pop),      32'(8'(1) << g));
    check_val("push_early", 32'(push),     32'h0);
    @(posedge clk); #1;
    mask = exp_push_mask(g, pk[15:8]);
    if (mask != 8'h00) pkt_m = pkt_m + 16'd1;
    else               drop_m = drop_m + 16'd1;
    check_val("push",      32'(push),     32'(mask));
    check_val("pop_clr",   32'(pop),      32'h0);
    check_val("busy_done", 32'(busy),     32'h0);
    check_val("pkt_cnt",   32'(pkt_cnt),  32'(pkt_m));
    check_val("drop_cnt",  32'(drop_cnt), 32'(drop_m));
    for (int j = 0; j < DRVRS; j++) check_val("dpush", 32'(D_push[j]), 32'(pk));
    fifo_pop(g);
    drive_fifos();
  endtask

  task automatic add_random_packets();
    int         n;
    int         f;
    int         cat;
    logic [7:0] d;
    n = $urandom_range(0, 2);
    for (int m = 0; m < n; m++) begin
      f   = $urandom_range(0, DRVRS - 1);
      cat = $urandom_range(0, 3);
      case (cat)
        0:       d = 8'((f + $urandom_range(1, DRVRS - 1)) % DRVRS);
        1:       d = 8'(f);
        2:       d = 8'($urandom_range(DRVRS, 254));
        default: d = 8'hFF;
      endcase
      fifo_push(f, {d, 8'($urandom)});
    end
  endtask

  initial begin
    int gobs;
    n_checks = 0;
    n_errors = 0;
    last_m   = DRVRS - 1;
    pkt_m    = '0;
    drop_m   = '0;
    for (int i = 0; i < DRVRS; i++) fifo_cnt[i] = 0;
    reset = 1'b0;

    // Reset with every driver requesting; two packets each, valid unicast dests.
    for (int i = 0; i < DRVRS; i++) begin
      fifo_push(i, {8'((i + 1) % DRVRS), 8'(i)});
      fifo_push(i, {8'((i + 2) % DRVRS), 8'(i + 8'h10)});
    end
    drive_fifos();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Round robin with all requests held: 0,1,...,7,0.
    for (int k = 0; k <= DRVRS; k++) begin
      serve_one(gobs);
      check_val("rr_order", 32'(gobs), 32'(k % DRVRS));
    end
    while (any_pending()) serve_one(gobs);

    // Unicast, broadcast and drops.
    fifo_push(3, 16'h05AB); drive_fifos(); serve_one(gobs);
    fifo_push(2, 16'hFF12); drive_fifos(); serve_one(gobs);
    fifo_push(1, 16'h0934); fifo_push(4, 16'h0400); drive_fifos();
    serve_one(gobs);
    serve_one(gobs);

    // Reset asserted during DELIVER aborts the packet.
    fifo_push(6, 16'h0312); drive_fifos();
    @(posedge clk); #1;
    check_val("mid_grant", 32'(grant_id), 32'd6);
    @(posedge clk); #1;
    check_val("mid_pop", 32'(pop), 32'h40);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(posedge clk); #1;
    check_val("mid_rst_nopush", 32'(push), 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    last_m = DRVRS - 1;
    pkt_m  = '0;
    drop_m = '0;
    serve_one(gobs);

    // Request withdrawn during ISSUE: no pop, back to idle.
    fifo_push(5, 16'h0111); drive_fifos();
    @(posedge clk); #1;
    check_val("wd_grant", 32'(grant_id), 32'd5);
    check_val("wd_busy",  32'(busy),     32'h1);
    last_m = 5;
    fifo_cnt[5] = 0;
    drive_fifos();
    @(posedge clk); #1;
    check_val("wd_nopop", 32'(pop),  32'h0);
    check_val("wd_idle",  32'(busy), 32'h0);
    @(posedge clk); #1;
    check_val("wd_stay",  32'(busy), 32'h0);
    check_val("wd_nopop2", 32'(pop), 32'h0);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      add_random_packets();
      drive_fifos();
      serve_one(gobs);
    end
    while (any_pending()) serve_one(gobs);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
